// File: rtl/apb_switch_ctrl.sv
// rtl/apb_switch_ctrl.sv - APB-mapped 32-bit switch debouncer with sticky change events and IRQ
//
// Ports:
//   PCLK, PRESETn        clock and asynchronous active-low reset
//   PSEL, PENABLE,       APB slave interface, zero wait states (PREADY tied high),
//   PWRITE, PADDR,       five word registers at BASE_ADDR:
//   PWDATA, PRDATA,      CTRL, DB_LIMIT, STATE, EVENT (W1C), MASK
//   PREADY
//   i_switch_raw         asynchronous switch pins
//   o_switch_state       debounced switch value (STATE register)
//   o_irq                registered interrupt request
module apb_switch_ctrl #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0040,
    parameter int          SYNC_STAGES = 2
) (
    input  logic        PCLK,
    input  logic        PRESETn,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    input  logic [31:0] i_switch_raw,
    output logic [31:0] o_switch_state,
    output logic        o_irq
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COUNT  = 2'd1,
        COMMIT = 2'd2
    } fsm_t;

    fsm_t        fsm_q, fsm_d;
    logic [31:0] sync_q [SYNC_STAGES];
    logic [31:0] sync_d [SYNC_STAGES];
    logic [31:0] cand_q, cand_d;
    logic [15:0] cnt_q, cnt_d;
    logic [1:0]  ctrl_q, ctrl_d;
    logic [15:0] db_limit_q, db_limit_d;
    logic [31:0] sw_state_q, sw_state_d;
    logic [31:0] event_q, event_d;
    logic [31:0] mask_q, mask_d;
    logic        irq_q, irq_d;

    logic [31:0] sync;
    logic [31:0] ev_set;
    logic [31:0] ev_clr;
    logic        wr_en;
    logic        rd_en;
    logic        sel_ctrl, sel_db, sel_state, sel_event, sel_mask;

    assign wr_en     = PSEL & PENABLE & PWRITE;
    assign rd_en     = PSEL & PENABLE & ~PWRITE;
    assign sel_ctrl  = (PADDR == BASE_ADDR);
    assign sel_db    = (PADDR == BASE_ADDR + 32'h04);
    assign sel_state = (PADDR == BASE_ADDR + 32'h08);
    assign sel_event = (PADDR == BASE_ADDR + 32'h0C);
    assign sel_mask  = (PADDR == BASE_ADDR + 32'h10);

    assign sync           = sync_q[SYNC_STAGES-1];
    assign PREADY         = 1'b1;
    assign o_switch_state = sw_state_q;
    assign o_irq          = irq_q;

    always_comb begin
        sync_d[0] = i_switch_raw;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end

        ctrl_d     = ctrl_q;
        db_limit_d = db_limit_q;
        mask_d     = mask_q;
        ev_clr     = '0;
        if (wr_en) begin
            if (sel_ctrl)  ctrl_d     = PWDATA[1:0];
            if (sel_db)    db_limit_d = PWDATA[15:0];
            if (sel_mask)  mask_d     = PWDATA;
            if (sel_event) ev_clr     = PWDATA;
        end

        fsm_d      = fsm_q;
        cand_d     = cand_q;
        cnt_d      = cnt_q;
        sw_state_d = sw_state_q;
        ev_set     = '0;
        if (!ctrl_q[0]) begin
            fsm_d = IDLE;
            cnt_d = '0;
        end else begin
            unique case (fsm_q)
                IDLE: begin
                    if (sync != sw_state_q) begin
                        cand_d = sync;
                        cnt_d  = '0;
                        fsm_d  = COUNT;
                    end
                end
                COUNT: begin
                    if (sync == sw_state_q) begin
                        fsm_d = IDLE;
                    end else if (sync != cand_q) begin
                        cand_d = sync;
                        cnt_d  = '0;
                    end else if (cnt_q >= db_limit_q) begin
                        // >= so a limit lowered below the running count commits at once
                        fsm_d = COMMIT;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                COMMIT: begin
                    sw_state_d = cand_q;
                    ev_set     = cand_q ^ sw_state_q;
                    fsm_d      = IDLE;
                end
                default: fsm_d = IDLE;
            endcase
        end

        // A commit setting a bit overrides a simultaneous W1C of that bit
        event_d = (event_q & ~ev_clr) | ev_set;
        irq_d   = ctrl_q[1] & |(event_q & mask_q);
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            fsm_q      <= IDLE;
            cand_q     <= '0;
            cnt_q      <= '0;
            ctrl_q     <= '0;
            db_limit_q <= 16'h00FF;
            sw_state_q <= '0;
            event_q    <= '0;
            mask_q     <= '0;
            irq_q      <= 1'b0;
        end else begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_d[i];
            end
            fsm_q      <= fsm_d;
            cand_q     <= cand_d;
            cnt_q      <= cnt_d;
            ctrl_q     <= ctrl_d;
            db_limit_q <= db_limit_d;
            sw_state_q <= sw_state_d;
            event_q    <= event_d;
            mask_q     <= mask_d;
            irq_q      <= irq_d;
        end
    end

    always_comb begin
        PRDATA = '0;
        if (PRESETn && rd_en) begin
            if (sel_ctrl)       PRDATA = {30'd0, ctrl_q};
            else if (sel_db)    PRDATA = {16'd0, db_limit_q};
            else if (sel_state) PRDATA = sw_state_q;
            else if (sel_event) PRDATA = event_q;
            else if (sel_mask)  PRDATA = mask_q;
        end
    end

endmodule

// File: tb/tb_apb_switch_ctrl.sv
// tb/tb_apb_switch_ctrl.sv - self-checking bench for apb_switch_ctrl
module tb_apb_switch_ctrl;

    localparam logic [31:0] A_CTRL  = 32'h0000_0040;
    localparam logic [31:0] A_DB    = 32'h0000_0044;
    localparam logic [31:0] A_STATE = 32'h0000_0048;
    localparam logic [31:0] A_EVENT = 32'h0000_004C;
    localparam logic [31:0] A_MASK  = 32'h0000_0050;
    localparam logic [31:0] A_UNMAP = 32'h0000_0054;

    logic        PCLK = 1'b0;
    logic        PRESETn;
    logic        PSEL, PENABLE, PWRITE;
    logic [31:0] PADDR, PWDATA, PRDATA;
    logic        PREADY;
    logic [31:0] i_switch_raw, o_switch_state;
    logic        o_irq;

    int total = 0;
    int bad   = 0;

    apb_switch_ctrl #(.BASE_ADDR(32'h0000_0040), .SYNC_STAGES(2)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
        .PREADY(PREADY), .i_switch_raw(i_switch_raw),
        .o_switch_state(o_switch_state), .o_irq(o_irq)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;   // write data, or expected read data
        string       name;
    } vec_t;

    vec_t tbl [22];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge PCLK);
        #1;
    endtask

    // Both tasks start right after an edge; the write lands on the second edge
    task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
        @(posedge PCLK); #1 PENABLE = 1'b1;
        @(posedge PCLK); #1 PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [31:0] a, output logic [31:0] d);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
        @(posedge PCLK); #1 PENABLE = 1'b1;
        @(negedge PCLK); d = PRDATA;
        @(posedge PCLK); #1 PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic read_check(input string name, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        apb_read(a, d);
        check(name, d, exp);
    endtask

    initial begin
        logic [31:0] rd;
        PRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = '0; PWDATA = '0; i_switch_raw = '0;

        // During reset: read access phase must still return 0
        tick(2);
        PSEL = 1'b1; PENABLE = 1'b1; PADDR = A_DB;
        @(negedge PCLK);
        check("rst_prdata", PRDATA, 32'h0);
        check("rst_pready", {31'd0, PREADY}, 32'h1);
        check("rst_state_out", o_switch_state, 32'h0);
        check("rst_irq", {31'd0, o_irq}, 32'h0);
        PSEL = 1'b0; PENABLE = 1'b0;
        tick(1);
        PRESETn = 1'b1;
        tick(1);

        tbl = '{
            '{1'b0, A_CTRL,        32'h0000_0000, "rst_ctrl"},
            '{1'b0, A_DB,          32'h0000_00FF, "rst_db"},
            '{1'b0, A_STATE,       32'h0000_0000, "rst_state"},
            '{1'b0, A_EVENT,       32'h0000_0000, "rst_event"},
            '{1'b0, A_MASK,        32'h0000_0000, "rst_mask"},
            '{1'b0, A_UNMAP,       32'h0000_0000, "rd_unmapped"},
            '{1'b1, A_CTRL,        32'hFFFF_FFFC, "wr_ctrl_hi"},
            '{1'b0, A_CTRL,        32'h0000_0000, "ctrl_unused_bits"},
            '{1'b1, A_CTRL,        32'hFFFF_FFFF, "wr_ctrl_all"},
            '{1'b0, A_CTRL,        32'h0000_0003, "ctrl_rw"},
            '{1'b1, A_CTRL,        32'h0000_0000, "wr_ctrl_zero"},
            '{1'b1, A_DB,          32'hABCD_1234, "wr_db"},
            '{1'b0, A_DB,          32'h0000_1234, "db_rw"},
            '{1'b1, A_MASK,        32'hA5A5_5A5A, "wr_mask"},
            '{1'b0, A_MASK,        32'hA5A5_5A5A, "mask_rw"},
            '{1'b1, A_STATE,       32'hFFFF_FFFF, "wr_state"},
            '{1'b0, A_STATE,       32'h0000_0000, "state_ro"},
            '{1'b1, 32'h0000_0041, 32'h0000_0003, "wr_misaligned"},
            '{1'b1, 32'h8000_0040, 32'h0000_0003, "wr_alias"},
            '{1'b0, A_CTRL,        32'h0000_0000, "ctrl_no_alias"},
            '{1'b1, A_EVENT,       32'hFFFF_FFFF, "wr_event_empty"},
            '{1'b0, 32'h8000_0050, 32'h0000_0000, "rd_alias"}
        };
        for (int i = 0; i < 22; i++) begin
            if (tbl[i].wr) apb_write(tbl[i].addr, tbl[i].data);
            else           read_check(tbl[i].name, tbl[i].addr, tbl[i].data);
        end
        read_check("event_still_zero", A_EVENT, 32'h0);

        // PRDATA is 0 outside the read access phase
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = A_DB;
        #1 check("prdata_setup_phase", PRDATA, 32'h0);
        PENABLE = 1'b1; PWRITE = 1'b1; PWDATA = 32'h0000_1234;
        #1 check("prdata_write_phase", PRDATA, 32'h0);
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        tick(1);

        // Scenario 1: 0 -> 1 with DB_LIMIT=3 lands 8 edges later
        apb_write(A_MASK, 32'h0);
        apb_write(A_DB, 32'd3);
        apb_write(A_CTRL, 32'h1);
        i_switch_raw = 32'h1;
        tick(7);
        @(negedge PCLK) check("s1_state_edge7", o_switch_state, 32'h0);
        tick(1);
        @(negedge PCLK) check("s1_state_edge8", o_switch_state, 32'h1);
        read_check("s1_event", A_EVENT, 32'h1);
        read_check("s1_state_reg", A_STATE, 32'h1);
        check("s1_irq_off", {31'd0, o_irq}, 32'h0);

        // Scenario 2: 2-cycle glitch on bit2 is filtered
        apb_write(A_EVENT, 32'h1);
        read_check("s2_event_cleared", A_EVENT, 32'h0);
        i_switch_raw = 32'h5;
        tick(2);
        i_switch_raw = 32'h1;
        tick(20);
        @(negedge PCLK) check("s2_state", o_switch_state, 32'h1);
        read_check("s2_event", A_EVENT, 32'h0);

        // Scenario 3: IRQ follows EVENT by a cycle, W1C drops it a cycle later
        apb_write(A_MASK, 32'h1);
        apb_write(A_CTRL, 32'h3);
        i_switch_raw = 32'h0;
        tick(7);
        @(negedge PCLK) check("s3_state_edge7", o_switch_state, 32'h1);
        tick(1);
        @(negedge PCLK);
        check("s3_state_edge8", o_switch_state, 32'h0);
        check("s3_irq_same_cycle", {31'd0, o_irq}, 32'h0);
        tick(1);
        @(negedge PCLK) check("s3_irq_set", {31'd0, o_irq}, 32'h1);
        apb_write(A_EVENT, 32'h1);
        @(negedge PCLK) check("s3_irq_hold", {31'd0, o_irq}, 32'h1);
        tick(1);
        @(negedge PCLK) check("s3_irq_clear", {31'd0, o_irq}, 32'h0);

        // Scenario 4: W1C on the commit edge loses to the set
        apb_write(A_CTRL, 32'h1);
        i_switch_raw = 32'h1;
        tick(6);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = A_EVENT; PWDATA = 32'h1;
        tick(1);
        PENABLE = 1'b1;
        tick(1);
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        @(negedge PCLK) check("s4_state", o_switch_state, 32'h1);
        read_check("s4_event_set_wins", A_EVENT, 32'h1);
        apb_write(A_EVENT, 32'h1);
        read_check("s4_event_cleared", A_EVENT, 32'h0);

        // Scenario 5: EN=0 freezes STATE/EVENT; re-enable debounces the pending change
        apb_write(A_CTRL, 32'h0);
        i_switch_raw = 32'h3;
        tick(20);
        @(negedge PCLK) check("s5_state_frozen", o_switch_state, 32'h1);
        read_check("s5_event_frozen", A_EVENT, 32'h0);
        apb_write(A_CTRL, 32'h1);
        tick(5);
        @(negedge PCLK) check("s5_state_w5", o_switch_state, 32'h1);
        tick(1);
        @(negedge PCLK) check("s5_state_w6", o_switch_state, 32'h3);
        read_check("s5_event", A_EVENT, 32'h2);
        apb_write(A_EVENT, 32'h2);

        // DB_LIMIT=0: minimum latency of 5 edges
        apb_write(A_DB, 32'd0);
        i_switch_raw = 32'h2;
        tick(4);
        @(negedge PCLK) check("lim0_edge4", o_switch_state, 32'h3);
        tick(1);
        @(negedge PCLK) check("lim0_edge5", o_switch_state, 32'h2);

        // Lowering DB_LIMIT below the running count commits on the next edge
        apb_write(A_DB, 32'd20);
        i_switch_raw = 32'h6;
        tick(10);
        apb_write(A_DB, 32'd2);
        @(negedge PCLK) check("lower_edge12", o_switch_state, 32'h2);
        tick(1);
        @(negedge PCLK) check("lower_edge13", o_switch_state, 32'h2);
        tick(1);
        @(negedge PCLK) check("lower_edge14", o_switch_state, 32'h6);

        // Scenario 6: reset mid-COUNT discards the change
        apb_write(A_MASK, 32'hF);
        apb_write(A_CTRL, 32'h3);
        apb_write(A_DB, 32'd10);
        i_switch_raw = 32'h0;
        tick(5);
        PRESETn = 1'b0;
        #1;
        check("s6_state_in_rst", o_switch_state, 32'h0);
        check("s6_irq_in_rst", {31'd0, o_irq}, 32'h0);
        tick(1);
        PRESETn = 1'b1;
        tick(1);
        read_check("s6_ctrl", A_CTRL, 32'h0);
        read_check("s6_db", A_DB, 32'h0000_00FF);
        read_check("s6_state", A_STATE, 32'h0);
        read_check("s6_event", A_EVENT, 32'h0);
        read_check("s6_mask", A_MASK, 32'h0);
        read_check("s6_unmapped", A_UNMAP, 32'h0);
        tick(30);
        @(negedge PCLK);
        check("s6_state_after", o_switch_state, 32'h0);
        check("s6_irq_after", {31'd0, o_irq}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
